// File: rtl/sparse_dispatch_pkg.sv
// Shared definitions for the sparse CSC dispatcher: width defaults,
// controller state encoding and the row-to-lane selection helper.
package sparse_dispatch_pkg;

  localparam int NUM_PU_DEF  = 4;
  localparam int D_WIDTH_DEF = 16;
  localparam int A_WIDTH_DEF = 4;
  localparam int W_WIDTH_DEF = 8;
  localparam int R_WIDTH_DEF = 6;

  // Lane index width; covers the largest supported lane count (16).
  localparam int SEL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_ACT = 3'd1,
    S_RD_P0  = 3'd2,
    S_RD_P1  = 3'd3,
    S_FETCH  = 3'd4,
    S_SEND   = 3'd5,
    S_DRAIN  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // Lane owning a row: low log2(num_pu) bits of the row; 0 for a single lane.
  function automatic logic [SEL_W-1:0] lane_sel(input logic [31:0] row,
                                                input int unsigned num_pu);
    logic [31:0] mask;
    mask = num_pu - 1;
    return SEL_W'(row & mask);
  endfunction

endpackage

// File: rtl/sparse_dispatch_if.sv
// Lane-side bus between the dispatcher and the PU array: one-hot valid,
// per-lane ready, shared triple payload and per-lane idle status.
interface sparse_dispatch_if #(
  parameter int NUM_PU  = sparse_dispatch_pkg::NUM_PU_DEF,
  parameter int D_WIDTH = sparse_dispatch_pkg::D_WIDTH_DEF,
  parameter int R_WIDTH = sparse_dispatch_pkg::R_WIDTH_DEF
);
  logic [NUM_PU-1:0]  lane_valid;
  logic [NUM_PU-1:0]  lane_ready;
  logic [D_WIDTH-1:0] lane_weight;
  logic [D_WIDTH-1:0] lane_act;
  logic [R_WIDTH-1:0] lane_row;
  logic [NUM_PU-1:0]  pu_idle;

  modport master (
    output lane_valid, lane_weight, lane_act, lane_row,
    input  lane_ready, pu_idle
  );

  modport slave (
    input  lane_valid, lane_weight, lane_act, lane_row,
    output lane_ready, pu_idle
  );
endinterface

// File: rtl/sparse_dispatch_lane_mux.sv
// Row-to-lane steering: turns the current row into a one-hot valid vector
// and returns the ready of the selected lane.
module sparse_dispatch_lane_mux
  import sparse_dispatch_pkg::*;
#(
  parameter int NUM_PU  = NUM_PU_DEF,
  parameter int R_WIDTH = R_WIDTH_DEF
) (
  input  logic               i_en,
  input  logic [R_WIDTH-1:0] i_row,
  input  logic [NUM_PU-1:0]  i_ready,
  output logic [NUM_PU-1:0]  o_valid,
  output logic               o_ready
);

  logic [SEL_W-1:0] w_sel;

  // Decode the owning lane and gate valid/ready by the offer enable
  always_comb begin
    w_sel   = lane_sel(32'(i_row), NUM_PU);
    o_valid = '0;
    o_ready = 1'b0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (w_sel == SEL_W'(i)) begin
        o_valid[i] = i_en;
        o_ready    = i_en & i_ready[i];
      end
    end
  end

endmodule

// File: rtl/sparse_dispatch.sv
// CSC sparse-matrix walker: reads activation, column pointers and v/z entries
// from 1-cycle-latency RAMs and offers (weight, act, row) triples to the lane
// owning each row, then waits for the PU array to settle before signalling done.
module sparse_dispatch
  import sparse_dispatch_pkg::*;
#(
  parameter int NUM_PU  = NUM_PU_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int R_WIDTH = R_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               skip_zero,
  input  logic [A_WIDTH-1:0] in_len,
  output logic [A_WIDTH-1:0] in_addr,
  input  logic [D_WIDTH-1:0] in_data,
  output logic [A_WIDTH:0]   p_addr,
  input  logic [W_WIDTH-1:0] p_data,
  output logic [W_WIDTH-1:0] vz_addr,
  input  logic [D_WIDTH-1:0] v_data,
  input  logic [R_WIDTH-1:0] z_data,
  sparse_dispatch_if.master  lane,
  output logic               busy,
  output logic               done
);

  state_t             r_state, w_next;
  logic [A_WIDTH-1:0] r_col, r_len;
  logic               r_skip, r_ph, r_idle_seen;
  logic [W_WIDTH-1:0] r_iter, r_pstart, r_end;
  logic [R_WIDTH-1:0] r_row_acc, r_row;
  logic [D_WIDTH-1:0] r_act, r_weight;

  logic               w_two_phase, w_zero_act, w_last_col, w_iter_last;
  logic               w_empty_col, w_accept, w_adv, w_offer;
  logic [R_WIDTH-1:0] w_next_row;

  // RAM reads take an address cycle (r_ph=0) then a capture cycle (r_ph=1)
  assign w_two_phase = (r_state == S_RD_ACT) || (r_state == S_RD_P1) || (r_state == S_FETCH);
  assign w_zero_act  = r_skip && (in_data == '0);
  assign w_last_col  = ({1'b0, r_col} + (A_WIDTH+1)'(1)) == {1'b0, r_len};
  assign w_iter_last = (r_iter + W_WIDTH'(1)) == r_end;
  assign w_empty_col = (p_data == r_pstart);
  assign w_next_row  = r_row_acc + R_WIDTH'(1) + z_data;
  assign w_offer     = (r_state == S_SEND);
  assign w_adv       = ((r_state == S_RD_ACT) && r_ph && w_zero_act) ||
                       ((r_state == S_RD_P1) && r_ph && w_empty_col) ||
                       (w_accept && w_iter_last);

  sparse_dispatch_lane_mux #(.NUM_PU(NUM_PU), .R_WIDTH(R_WIDTH)) u_mux (
    .i_en    (w_offer),
    .i_row   (r_row),
    .i_ready (lane.lane_ready),
    .o_valid (lane.lane_valid),
    .o_ready (w_accept)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic: column walk, value fetch/send loop, drain and done
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (in_len == '0) ? S_DRAIN : S_RD_ACT;
      S_RD_ACT: if (r_ph) w_next = w_zero_act ? (w_last_col ? S_DRAIN : S_RD_ACT) : S_RD_P0;
      S_RD_P0:  w_next = S_RD_P1;
      S_RD_P1:  if (r_ph) w_next = w_empty_col ? (w_last_col ? S_DRAIN : S_RD_ACT) : S_FETCH;
      S_FETCH:  if (r_ph) w_next = S_SEND;
      S_SEND:   if (w_accept) w_next = w_iter_last ? (w_last_col ? S_DRAIN : S_RD_ACT) : S_FETCH;
      S_DRAIN:  if (r_idle_seen && (&lane.pu_idle)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: RAM addresses per read state, payload only while offering
  always_comb begin
    in_addr          = '0;
    p_addr           = '0;
    vz_addr          = '0;
    lane.lane_weight = '0;
    lane.lane_act    = '0;
    lane.lane_row    = '0;
    busy             = (r_state != S_IDLE);
    done             = (r_state == S_DONE);
    case (r_state)
      S_RD_ACT: in_addr = r_col;
      S_RD_P0:  p_addr  = {1'b0, r_col};
      S_RD_P1:  p_addr  = {1'b0, r_col} + (A_WIDTH+1)'(1);
      S_FETCH:  vz_addr = r_iter;
      S_SEND: begin
        lane.lane_weight = r_weight;
        lane.lane_act    = r_act;
        lane.lane_row    = r_row;
      end
      default: ;
    endcase
  end

  // Control counters: column index, read phase, value iterator, row accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col       <= '0;
      r_len       <= '0;
      r_skip      <= 1'b0;
      r_ph        <= 1'b0;
      r_iter      <= '0;
      r_row_acc   <= '0;
      r_idle_seen <= 1'b0;
    end else begin
      r_ph        <= w_two_phase && !r_ph;
      r_idle_seen <= (r_state == S_DRAIN) && (&lane.pu_idle);
      if ((r_state == S_IDLE) && start) begin
        r_col  <= '0;
        r_len  <= in_len;
        r_skip <= skip_zero;
      end
      if (w_adv && !w_last_col) r_col <= r_col + A_WIDTH'(1);
      if ((r_state == S_RD_P1) && !r_ph) r_iter <= p_data;
      // Row accumulator starts at -1 so the first row equals its zero-run count
      if ((r_state == S_RD_P1) && r_ph) r_row_acc <= '1;
      if (w_accept) begin
        r_row_acc <= r_row;
        r_iter    <= r_iter + W_WIDTH'(1);
      end
    end
  end

  // Captured RAM data: activation, column bounds and the pending triple
  always_ff @(posedge clk) begin
    if ((r_state == S_RD_ACT) && r_ph) r_act <= in_data;
    if ((r_state == S_RD_P1) && !r_ph) r_pstart <= p_data;
    if ((r_state == S_RD_P1) && r_ph)  r_end <= p_data;
    if ((r_state == S_FETCH) && r_ph) begin
      r_row    <= w_next_row;
      r_weight <= v_data;
    end
  end

endmodule

// File: tb/tb_sparse_dispatch.sv
// Self-checking bench for sparse_dispatch: RAM models, a column-walk reference
// model producing the expected triple stream, and per-cycle handshake checks.
module tb_sparse_dispatch;

  localparam int NP = 4, DW = 16, AW = 4, WW = 8, RW = 6;

  typedef struct packed {
    logic [DW-1:0] w;
    logic [DW-1:0] a;
    logic [RW-1:0] r;
  } trip_t;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, skip_zero = 1'b0;
  logic [AW-1:0] in_len = '0, in_addr;
  logic [DW-1:0] in_data, v_data;
  logic [AW:0]   p_addr;
  logic [WW-1:0] p_data, vz_addr;
  logic [RW-1:0] z_data;
  logic          busy, done;

  sparse_dispatch_if #(.NUM_PU(NP), .D_WIDTH(DW), .R_WIDTH(RW)) lif ();

  sparse_dispatch #(.NUM_PU(NP), .D_WIDTH(DW), .A_WIDTH(AW), .W_WIDTH(WW), .R_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_zero(skip_zero), .in_len(in_len),
    .in_addr(in_addr), .in_data(in_data), .p_addr(p_addr), .p_data(p_data),
    .vz_addr(vz_addr), .v_data(v_data), .z_data(z_data), .lane(lif),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] act_mem [16];
  logic [WW-1:0] p_mem   [32];
  logic [DW-1:0] v_mem   [256];
  logic [RW-1:0] z_mem   [256];

  always @(posedge clk) begin
    in_data <= act_mem[in_addr];
    p_data  <= p_mem[p_addr];
    v_data  <= v_mem[vz_addr];
    z_data  <= z_mem[vz_addr];
  end

  int    n_chk = 0, n_fail = 0;
  trip_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++)  act_mem[i] = '0;
    for (int i = 0; i < 32; i++)  p_mem[i] = '0;
    for (int i = 0; i < 256; i++) begin v_mem[i] = '0; z_mem[i] = '0; end
  endtask

  // Matrix used by the directed cases: act={3,5}, col0 z={0,1} v={7,9}, col1 z={2} v={4}
  task automatic load_t1();
    clear_mem();
    act_mem[0] = 16'd3; act_mem[1] = 16'd5;
    p_mem[0] = 8'd0; p_mem[1] = 8'd2; p_mem[2] = 8'd3;
    z_mem[0] = 6'd0; z_mem[1] = 6'd1; z_mem[2] = 6'd2;
    v_mem[0] = 16'd7; v_mem[1] = 16'd9; v_mem[2] = 16'd4;
  endtask

  task automatic gen_layer(input int len, input int zero_pct);
    int ptr, nnz;
    clear_mem();
    ptr = 0;
    for (int c = 0; c < len; c++) begin
      p_mem[c]   = WW'(ptr);
      act_mem[c] = ($urandom_range(99) < zero_pct) ? '0 : DW'($urandom_range(65535, 1));
      nnz = $urandom_range(3);
      for (int k = 0; k < nnz; k++) begin
        v_mem[ptr] = DW'($urandom);
        z_mem[ptr] = RW'($urandom_range(4));
        ptr++;
      end
    end
    p_mem[len] = WW'(ptr);
  endtask

  // Reference: every stored value of every non-skipped column in column order;
  // its row is the previous row plus one plus its zero run, starting from -1.
  task automatic build_expect(input int len, input bit skip);
    exp_q.delete();
    for (int c = 0; c < len; c++) begin
      int racc;
      racc = -1;
      if (skip && act_mem[c] == '0) continue;
      for (int k = int'(p_mem[c]); k < int'(p_mem[c+1]); k++) begin
        trip_t t;
        racc = (racc + 1 + int'(z_mem[k])) % (1 << RW);
        t.w = v_mem[k];
        t.a = act_mem[c];
        t.r = RW'(racc);
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic run_layer(input int len, input bit skip, input int rdy_pct, input int idle_hold,
                           input bit block1, input bit start_noise,
                           output int pcnt, output int nheld);
    int            hold, ndone, blk, lastlow;
    bit            fin, pend, acc;
    logic [1:0]    hist;
    logic [NP-1:0] v, sv_vld;
    trip_t         sv, t;
    build_expect(len, skip);
    hold = 0; ndone = 0; blk = 0; lastlow = -100; fin = 0; pend = 0; hist = '0;
    pcnt = 0; nheld = 0; sv = '0; sv_vld = '0;
    @(negedge clk);
    start = 1'b1; skip_zero = skip; in_len = AW'(len);
    lif.lane_ready = '1; lif.pu_idle = '1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (fin) begin
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
        break;
      end
      start = start_noise && cyc >= 3 && cyc < 6;
      lif.pu_idle = (hold > 0) ? '0 : '1;
      if (hold > 0) begin hold--; lastlow = cyc; end
      for (int i = 0; i < NP; i++) lif.lane_ready[i] = ($urandom_range(99) < rdy_pct);
      if (block1 && lif.lane_valid == NP'(2) && blk < 10) begin
        lif.lane_ready[1] = 1'b0;
        blk++;
      end
      v = lif.lane_valid;
      if (busy && p_addr == 5'd1) pcnt++;
      chk("busy", busy, 1);
      if (v != '0) begin
        chk("onehot", $onehot(v), 1);
        if (pend) begin
          chk("hold_vld", v, sv_vld);
          chk("hold_data", {lif.lane_weight, lif.lane_act, lif.lane_row}, sv);
        end
        acc = |(v & lif.lane_ready);
        if (acc) begin
          if (exp_q.size() == 0) chk("extra_dispatch", 1, 0);
          else begin
            t = exp_q.pop_front();
            chk("weight", lif.lane_weight, t.w);
            chk("act", lif.lane_act, t.a);
            chk("row", lif.lane_row, t.r);
            chk("lane", v, NP'(1) << (t.r % NP));
            if (exp_q.size() == 0) hold = idle_hold;
          end
        end else nheld++;
        pend   = !acc;
        sv_vld = v;
        sv     = {lif.lane_weight, lif.lane_act, lif.lane_row};
      end else if (pend) begin
        chk("retract", v, sv_vld);
        pend = 0;
      end
      if (done) begin
        ndone++;
        chk("idle_before_done", hist, 2'b11);
        if (idle_hold > 0) chk("drain_lat", cyc - lastlow, 3);
        if (len == 0) chk("empty_lat", cyc, 2);
        fin = 1;
      end
      hist = {hist[0], &lif.pu_idle};
      @(negedge clk);
    end
    start = 1'b0;
    lif.pu_idle = '1;
    chk("timeout", fin, 1);
    chk("left_over", exp_q.size(), 0);
    chk("done_count", ndone, 1);
  endtask

  initial begin
    int pc0, pc1, nh, n;
    lif.lane_ready = '1;
    lif.pu_idle    = '1;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, lif.lane_valid}, 0);
    chk("rst_bus", {in_addr, p_addr, vz_addr, lif.lane_weight, lif.lane_act, lif.lane_row}, 0);
    rst = 1'b1;

    // Directed matrix, full readiness then random backpressure
    load_t1();
    run_layer(2, 0, 100, 0, 0, 0, pc0, nh);
    run_layer(2, 0, 35, 0, 0, 0, pc0, nh);

    // Zero activation skipping: column 0 must not be walked when skipping
    load_t1();
    act_mem[0] = 16'd0; act_mem[1] = 16'd6;
    run_layer(2, 1, 100, 0, 0, 0, pc1, nh);
    run_layer(2, 0, 100, 0, 0, 0, pc0, nh);
    chk("p_col0_skip", pc1 < pc0, 1);

    // Lane 1 stalled for 10 offered cycles on row 5
    clear_mem();
    act_mem[0] = 16'd2; p_mem[0] = 8'd0; p_mem[1] = 8'd1;
    z_mem[0] = 6'd5; v_mem[0] = 16'h1234;
    run_layer(1, 0, 100, 0, 1, 0, pc0, nh);
    chk("held_cycles", nh, 10);

    // Empty columns and zero-length layer
    clear_mem();
    act_mem[0] = 16'd1; act_mem[1] = 16'd2;
    p_mem[0] = 8'd0; p_mem[1] = 8'd0; p_mem[2] = 8'd0; p_mem[3] = 8'd2;
    run_layer(2, 0, 100, 0, 0, 0, pc0, nh);
    run_layer(0, 0, 100, 0, 0, 0, pc0, nh);

    // Reset while a triple is being offered
    load_t1();
    @(negedge clk);
    lif.lane_ready = '0; start = 1'b1; in_len = 4'd2; skip_zero = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 50 && lif.lane_valid == '0; n++) @(negedge clk);
    chk("rst_pre_valid", lif.lane_valid != '0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {busy, done, lif.lane_valid}, 0);
    chk("midrst_bus", {in_addr, p_addr, vz_addr, lif.lane_weight, lif.lane_act, lif.lane_row}, 0);
    rst = 1'b1; lif.lane_ready = '1;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", {busy, lif.lane_valid}, 0);
    end
    run_layer(2, 0, 100, 0, 0, 0, pc0, nh);

    // Slow PU drain and start pulses while busy
    load_t1();
    run_layer(2, 0, 100, 20, 0, 1, pc0, nh);

    // Randomised layers
    for (int r = 0; r < 10; r++) begin
      int len;
      bit skp;
      len = $urandom_range(15, 1);
      skp = 1'($urandom_range(1));
      gen_layer(len, 30);
      run_layer(len, skp, (r % 3 == 0) ? 100 : 30 + 10 * (r % 3), 0, 0, 0, pc0, nh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
